// File: rtl/ifetch_queue_pkg.sv
// Shared control encodings for the fetch path: FSM states, next-PC selectors,
// and the buffered fetch-entry payload.
package ifetch_queue_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ENTRY_W = 2 * XLEN + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } ifq_state_e;

  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_JMP = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer of fetched entries with push, pop, synchronous clear and occupancy count.
module ifq_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  ifq_entry_t             push_data,
  input  logic                   pop,
  output ifq_entry_t             head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  ifq_entry_t             mem_q [DEPTH];
  ifq_entry_t             mem_d [DEPTH];
  logic       [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic       [CNT_W-1:0] cnt_q, cnt_d;
  logic                   do_push, do_pop;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    do_pop  = pop && (cnt_q != '0);
    do_push = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_data;
        wr_d        = wr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_d = rd_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues one memory read at a time, buffers results
// for decode, and discards work on a redirect flush.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [XLEN-1:0] req_addr,
  output logic            req_ready,
  input  logic            flush,
  output logic            mem_rd,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic            out_fault,
  input  logic            out_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  ifq_state_e      state_q, state_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic            mem_rd_q, mem_rd_d;
  logic            push;
  ifq_entry_t      push_entry;
  ifq_entry_t      head;
  logic [CNT_W-1:0] count;
  logic            pop;

  assign req_ready = (state_q == IDLE) && (count < CNT_W'(DEPTH)) && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Next-state, read issue and push selection.
  always_comb begin
    state_d    = state_q;
    pend_pc_d  = pend_pc_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = 1'b0;
    push       = 1'b0;
    push_entry = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          if (req_addr[1:0] == 2'b00) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = req_addr;
            pend_pc_d  = req_addr;
            state_d    = BUSY;
          end else begin
            push       = 1'b1;
            push_entry = '{pc: req_addr, instr: '0, fault: 1'b1};
          end
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = mem_rvalid ? IDLE : DROP;
        end else if (mem_rvalid) begin
          push       = 1'b1;
          push_entry = '{pc: pend_pc_q, instr: mem_rdata, fault: 1'b0};
          state_d    = IDLE;
        end
      end
      DROP: begin
        // The stale response closes the read even if another flush lands with it.
        if (mem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_pc_q  <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_pc_q  <= pend_pc_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
    end
  end

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_instr = out_valid ? head.instr : '0;
  assign out_fault = out_valid ? head.fault : 1'b0;

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of fetched-instruction entries buffered (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  PC side presents a fetch address.
REQ-005 SHALL have port req_addr  input  32  byte address of the instruction to fetch.
REQ-006 SHALL have port req_ready  output  1  fetch request accepted this cycle when high with req_valid.
REQ-007 SHALL have port flush  input  1  redirect (branch/jump/jr taken); discard all buffered and in-flight fetches.
REQ-008 SHALL have ports mem_rd  output  1 and mem_addr  output  32: single-cycle read strobe and word address to instruction memory.
REQ-009 SHALL have ports mem_rvalid  input  1 and mem_rdata  input  32: read-data return, arbitrary latency of 1 or more cycles after mem_rd.
REQ-010 SHALL have ports out_valid  output  1, out_pc  output  32, out_instr  output  32, out_fault  output  1, out_ready  input  1: decode-side FIFO head and pop handshake.

Function
REQ-011 SHALL implement the FSM states IDLE, BUSY (read outstanding) and DROP (read outstanding, result to be discarded).
REQ-012 SHALL drive req_ready = (state==IDLE) && (count<DEPTH) && !flush, combinationally.
REQ-013 SHALL, on accept with req_addr[1:0]==0, assert mem_rd for exactly the next cycle with mem_addr=req_addr, latch req_addr as pending PC, and move to BUSY.
REQ-014 SHALL, on accept with req_addr[1:0]!=0, issue no memory read, push {pc=req_addr, instr=0, fault=1} next cycle and stay IDLE.
REQ-015 SHALL, in BUSY with mem_rvalid and no flush, push {pending PC, mem_rdata, fault=0} and return to IDLE.
REQ-016 SHALL allow at most one outstanding memory read; mem_rvalid in IDLE SHALL be ignored.
REQ-017 SHALL drive out_valid = (count!=0); out_pc/out_instr/out_fault SHALL show the head entry, 0 when empty.
REQ-018 SHALL pop the head when out_valid && out_ready; push and pop in the same cycle leave count unchanged.
REQ-019 SHALL, on flush, clear count, head and tail pointers next cycle; any pop or push requested that cycle is void.
REQ-020 SHALL, on flush in BUSY without mem_rvalid, move to DROP; with mem_rvalid in the same cycle, discard the data and move to IDLE.
REQ-021 SHALL, in DROP, discard the next mem_rvalid and move to IDLE; flush in DROP keeps DROP.
REQ-022 SHALL wrap head/tail pointers modulo DEPTH; count width SHALL be clog2(DEPTH)+1 bits.

Reset
REQ-023 SHALL, while rst is high, hold state=IDLE, count=0, pointers=0, mem_rd=0, mem_addr=0, pending PC=0, out_valid=0, out_pc=0, out_instr=0, out_fault=0.
REQ-024 SHALL discard any read outstanding at reset; a mem_rvalid arriving after reset in IDLE is ignored.

Structure
REQ-025 SHALL take FSM state encodings (IDLE=2'd0, BUSY=2'd1, DROP=2'd2) from the shared control-encoding definitions file alongside the NPC_* selectors.
REQ-026 SHALL contain one sub-module, ifq_fifo (DEPTH x 65-bit storage with push, pop, clear, count); the FSM stays in ifetch_queue.

Verification
REQ-027 Reset then req 0x0000_3000, mem returns 0x2001_0005 after 3 cycles -> mem_rd one cycle with mem_addr 0x0000_3000; out_valid, out_pc 0x0000_3000, out_instr 0x2001_0005, fault 0.
REQ-028 out_ready=0, four fetches 0x3000..0x300C -> count 4, req_ready low on fifth request; one pop -> req_ready high again, head 0x3004.
REQ-029 Flush one cycle after mem_rd for 0x3008, rvalid 2 cycles later -> DROP then IDLE, response discarded, out_valid 0.
REQ-030 Flush coincident with mem_rvalid in BUSY -> data dropped, IDLE next cycle, count 0.
REQ-031 req_addr 0x0000_3002 -> no mem_rd; entry pc 0x0000_3002, instr 0, out_fault 1.
REQ-032 rst asserted mid-BUSY with 2 entries queued -> all outputs 0 immediately; post-reset stray mem_rvalid ignored.
